// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the AES-128 decryption core:
//   - data-path widths (TEXT_WIDTH, KEY_WIDTH, FOUR_BYTE_WIDTH)
//   - the control FSM state encoding
//   - the round-constant table (Rcon_1..Rcon_10)
//   - GF(2^8) helpers (xtime, gf_mul)
//   - byte-permutation helpers (InvShiftRows, RotWord)
// Byte order is FIPS-197: byte 0 is bits [127:120], bytes fill columns first.
// -----------------------------------------------------------------------------
package aes_pkg;

  localparam int TEXT_WIDTH      = 128;
  localparam int KEY_WIDTH       = 128;
  localparam int FOUR_BYTE_WIDTH = 32;

  // One block walks FETCH -> LOAD -> (KEY_ISSUE/KEY_CAP) x10 -> ARK
  // -> (RND_ISSUE/RND_CAP) x10 -> FINISH, then back to FETCH or on to DONE.
  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_LOAD      = 4'd1,
    ST_KEY_ISSUE = 4'd2,
    ST_KEY_CAP   = 4'd3,
    ST_ARK       = 4'd4,
    ST_RND_ISSUE = 4'd5,
    ST_RND_CAP   = 4'd6,
    ST_FINISH    = 4'd7,
    ST_DONE      = 4'd8
  } aes_state_e;

  // Round constant for round index 1..10; any other index yields zero.
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] rc;
    case (idx)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a small constant (InvMixColumns only needs 09/0b/0d/0e,
  // so a 4-bit multiplier is enough).
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 4; i++) begin
      p = p ^ (k[i] ? x : 8'h00);
      x = xtime(x);
    end
    return p;
  endfunction

  // Row r of the 4x4 byte matrix is rotated right by r positions.
  function automatic logic [TEXT_WIDTH-1:0] inv_shift_rows(input logic [TEXT_WIDTH-1:0] s);
    logic [TEXT_WIDTH-1:0] o;
    o = {TEXT_WIDTH{1'b0}};
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  // Cyclic left rotation of a key word by one byte.
  function automatic logic [FOUR_BYTE_WIDTH-1:0] rot_word(input logic [FOUR_BYTE_WIDTH-1:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_inv_mixcolumns.sv
// -----------------------------------------------------------------------------
// aes_inv_mixcolumns
// Purely combinational InvMixColumns over a full 128-bit state.
// Ports:
//   data_i  in  128  state before InvMixColumns
//   data_o  out 128  state after InvMixColumns
// Each column [a0 a1 a2 a3] is multiplied by the circulant matrix
// (0e 0b 0d 09) in GF(2^8).
// -----------------------------------------------------------------------------
module aes_inv_mixcolumns
  import aes_pkg::*;
(
  input  logic [TEXT_WIDTH-1:0] data_i,
  output logic [TEXT_WIDTH-1:0] data_o
);

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0;
    logic [7:0] a1;
    logic [7:0] a2;
    logic [7:0] a3;
    {a0, a1, a2, a3} = col;
    return {gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9),
            gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd),
            gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb),
            gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he)};
  endfunction

  assign data_o[127:96] = inv_mix_col(data_i[127:96]);
  assign data_o[95:64]  = inv_mix_col(data_i[95:64]);
  assign data_o[63:32]  = inv_mix_col(data_i[63:32]);
  assign data_o[31:0]   = inv_mix_col(data_i[31:0]);

endmodule

// File: rtl/aes_core.sv
// -----------------------------------------------------------------------------
// aes_core
// AES-128 decryption engine. For each block address (0 .. NUM_BLOCKS-1) it
// fetches ciphertext and key from a registered ROM, runs the forward key
// schedule up to round key 10, then the inverse cipher while walking the key
// schedule backwards. S-box lookups are done by two external synchronous ROMs:
// the core presents a lookup address in an ISSUE cycle and consumes the data
// in the following CAP cycle.
//
// Ports:
//   clk_i               in   1    clock, rising edge
//   rst_ni              in   1    asynchronous active-low reset
//   cyphertext_i        in   128  ciphertext at pc_o (one-cycle ROM latency)
//   key_i               in   128  cipher key at pc_o (same timing)
//   W3_i                in   32   S-box(W3_o), one cycle later
//   subbyte_addround_i  in   128  InvS-box(shift_subbyte_o), one cycle later
//   m3_reg_o            out  128  state register; plaintext while finish_o
//   finish_o            out  1    one-cycle plaintext-valid strobe
//   pc_o                out  ADDR_WIDTH  current block address
//   shift_subbyte_o     out  128  InvShiftRows(state), combinational
//   W3_o                out  32   RotWord of the key word to substitute
//
// Build option: AES_KEY_REUSE_EN - caches the last raw key and its round-10
// key; a block whose key matches the valid cache skips key expansion
// (24 instead of 44 cycles per block).
// -----------------------------------------------------------------------------
module aes_core
  import aes_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_BLOCKS = 12
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [TEXT_WIDTH-1:0]      cyphertext_i,
  input  logic [KEY_WIDTH-1:0]       key_i,
  input  logic [FOUR_BYTE_WIDTH-1:0] W3_i,
  input  logic [TEXT_WIDTH-1:0]      subbyte_addround_i,
  output logic [TEXT_WIDTH-1:0]      m3_reg_o,
  output logic                       finish_o,
  output logic [ADDR_WIDTH-1:0]      pc_o,
  output logic [TEXT_WIDTH-1:0]      shift_subbyte_o,
  output logic [FOUR_BYTE_WIDTH-1:0] W3_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_PC = ADDR_WIDTH'(NUM_BLOCKS - 1);

  aes_state_e                 state_q;
  logic [TEXT_WIDTH-1:0]      text_q;
  logic [KEY_WIDTH-1:0]       key_q;
  logic [3:0]                 rnd_q;
  logic [ADDR_WIDTH-1:0]      pc_q;
  logic                       finish_q;

`ifdef AES_KEY_REUSE_EN
  logic [KEY_WIDTH-1:0]       cache_key_q;
  logic [KEY_WIDTH-1:0]       cache_k10_q;
  logic                       cache_vld_q;
`endif

  logic [FOUR_BYTE_WIDTH-1:0] rcon_word_d;
  logic [FOUR_BYTE_WIDTH-1:0] fw0_d;
  logic [FOUR_BYTE_WIDTH-1:0] fw1_d;
  logic [FOUR_BYTE_WIDTH-1:0] fw2_d;
  logic [FOUR_BYTE_WIDTH-1:0] fw3_d;
  logic [KEY_WIDTH-1:0]       key_fwd_d;
  logic [KEY_WIDTH-1:0]       key_inv_d;
  logic [TEXT_WIDTH-1:0]      round_add_d;
  logic [TEXT_WIDTH-1:0]      round_mix_d;

  // Next round key in either direction. The forward step uses
  // SubWord(RotWord(w3)); the backward step needs SubWord(RotWord(v3)) with
  // v3 = w3 ^ w2 of the key being rolled back, which is what W3_o issued.
  always_comb begin
    rcon_word_d = {rcon(rnd_q), 24'h000000};
    fw0_d       = key_q[127:96] ^ W3_i ^ rcon_word_d;
    fw1_d       = key_q[95:64] ^ fw0_d;
    fw2_d       = key_q[63:32] ^ fw1_d;
    fw3_d       = key_q[31:0] ^ fw2_d;
    key_fwd_d   = {fw0_d, fw1_d, fw2_d, fw3_d};
    key_inv_d   = {key_q[127:96] ^ W3_i ^ rcon_word_d,
                   key_q[127:96] ^ key_q[95:64],
                   key_q[95:64] ^ key_q[63:32],
                   key_q[63:32] ^ key_q[31:0]};
    round_add_d = subbyte_addround_i ^ key_inv_d;
  end

  aes_inv_mixcolumns u_inv_mixcolumns (
    .data_i (round_add_d),
    .data_o (round_mix_d)
  );

  // Key-word lookup address: only driven during ISSUE cycles.
  always_comb begin
    case (state_q)
      ST_KEY_ISSUE: W3_o = rot_word(key_q[31:0]);
      ST_RND_ISSUE: W3_o = rot_word(key_q[31:0] ^ key_q[63:32]);
      default:      W3_o = 32'h0000_0000;
    endcase
  end

  assign shift_subbyte_o = inv_shift_rows(text_q);
  assign m3_reg_o        = text_q;
  assign finish_o        = finish_q;
  assign pc_o            = pc_q;

  // Block sequencer: FSM, round counter, key schedule, state and outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_FETCH;
      text_q      <= {TEXT_WIDTH{1'b0}};
      key_q       <= {KEY_WIDTH{1'b0}};
      rnd_q       <= 4'd0;
      pc_q        <= {ADDR_WIDTH{1'b0}};
      finish_q    <= 1'b0;
`ifdef AES_KEY_REUSE_EN
      cache_key_q <= {KEY_WIDTH{1'b0}};
      cache_k10_q <= {KEY_WIDTH{1'b0}};
      cache_vld_q <= 1'b0;
`endif
    end else begin
      finish_q <= 1'b0;
      case (state_q)
        // ROM registers the block at pc_o during this cycle.
        ST_FETCH: begin
          state_q <= ST_LOAD;
        end

        ST_LOAD: begin
          text_q <= cyphertext_i;
`ifdef AES_KEY_REUSE_EN
          if (cache_vld_q && (key_i == cache_key_q)) begin
            key_q   <= cache_k10_q;
            rnd_q   <= 4'd10;
            state_q <= ST_ARK;
          end else begin
            // Cache stays invalid until this key has been fully expanded.
            key_q       <= key_i;
            cache_key_q <= key_i;
            cache_vld_q <= 1'b0;
            rnd_q       <= 4'd1;
            state_q     <= ST_KEY_ISSUE;
          end
`else
          key_q   <= key_i;
          rnd_q   <= 4'd1;
          state_q <= ST_KEY_ISSUE;
`endif
        end

        ST_KEY_ISSUE: begin
          state_q <= ST_KEY_CAP;
        end

        ST_KEY_CAP: begin
          key_q <= key_fwd_d;
          if (rnd_q == 4'd10) begin
            state_q <= ST_ARK;
`ifdef AES_KEY_REUSE_EN
            cache_k10_q <= key_fwd_d;
            cache_vld_q <= 1'b1;
`endif
          end else begin
            rnd_q   <= rnd_q + 4'd1;
            state_q <= ST_KEY_ISSUE;
          end
        end

        // Initial AddRoundKey with k10; rnd_q already sits at 10.
        ST_ARK: begin
          text_q  <= text_q ^ key_q;
          state_q <= ST_RND_ISSUE;
        end

        ST_RND_ISSUE: begin
          state_q <= ST_RND_CAP;
        end

        // key_q rolls back to k_{r-1}; the last round has no InvMixColumns.
        ST_RND_CAP: begin
          key_q <= key_inv_d;
          if (rnd_q == 4'd1) begin
            text_q   <= round_add_d;
            finish_q <= 1'b1;
            state_q  <= ST_FINISH;
          end else begin
            text_q  <= round_mix_d;
            rnd_q   <= rnd_q - 4'd1;
            state_q <= ST_RND_ISSUE;
          end
        end

        ST_FINISH: begin
          if (pc_q == LAST_PC) begin
            state_q <= ST_DONE;
          end else begin
            pc_q    <= pc_q + ADDR_WIDTH'(1);
            state_q <= ST_FETCH;
          end
        end

        // Terminal until the next reset.
        ST_DONE: begin
          state_q <= ST_DONE;
        end

        default: begin
          state_q <= ST_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_core.sv
// -----------------------------------------------------------------------------
// tb_aes_core
// Self-checking bench for aes_core: registered ciphertext/key ROM and S-box ROM
// models, a byte-level AES-128 reference decryptor, and a cycle schedule of the
// expected finish strobes.
// -----------------------------------------------------------------------------
module tb_aes_core;

  localparam int AW = 8;
  localparam int NB = 12;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K10_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [127:0]  cyphertext_i;
  logic [127:0]  key_i;
  logic [31:0]   W3_i;
  logic [127:0]  subbyte_addround_i;
  logic [127:0]  m3_reg_o;
  logic          finish_o;
  logic [AW-1:0] pc_o;
  logic [127:0]  shift_subbyte_o;
  logic [31:0]   W3_o;

  aes_core #(.ADDR_WIDTH(AW), .NUM_BLOCKS(NB)) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .cyphertext_i       (cyphertext_i),
    .key_i              (key_i),
    .W3_i               (W3_i),
    .subbyte_addround_i (subbyte_addround_i),
    .m3_reg_o           (m3_reg_o),
    .finish_o           (finish_o),
    .pc_o               (pc_o),
    .shift_subbyte_o    (shift_subbyte_o),
    .W3_o               (W3_o)
  );

  always #5 clk_i = ~clk_i;

  int           total = 0;
  int           bad = 0;
  int           cyc;
  int           nstrobe;
  logic [7:0]   sbox [256];
  logic [7:0]   isbox [256];
  logic [127:0] mem_ct [NB];
  logic [127:0] mem_key [NB];
  logic [127:0] exp_pt [NB];
  logic [127:0] exp_k10 [NB];
  int           exp_t [NB];
  bit           exp_hit [NB];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  function automatic logic [127:0] inv_sub(input logic [127:0] v);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = isbox[v[127-8*i -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] inv_shift(input logic [127:0] v);
    logic [7:0]   m [4][4];
    logic [7:0]   t;
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) m[r][c] = v[127-8*(4*c+r) -: 8];
    for (int r = 1; r < 4; r++) begin
      for (int n = 0; n < r; n++) begin
        t = m[r][3]; m[r][3] = m[r][2]; m[r][2] = m[r][1]; m[r][1] = m[r][0]; m[r][0] = t;
      end
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) o[127-8*(4*c+r) -: 8] = m[r][c];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] v);
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    logic [127:0] o;
    coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(coef[(j-r+4)%4], v[127-8*(4*c+j) -: 8]);
        o[127-8*(4*c+r) -: 8] = acc;
      end
    end
    return o;
  endfunction

  // Textbook 44-word key schedule; returns round key r.
  function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] decrypt(input logic [127:0] ct, input logic [127:0] key);
    logic [127:0] s;
    s = ct ^ round_key(key, 10);
    for (int r = 9; r >= 0; r--) begin
      s = inv_sub(inv_shift(s)) ^ round_key(key, r);
      if (r > 0) s = inv_mix(s);
    end
    return s;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- external ROM models (one-cycle latency) ----------------
  always @(posedge clk_i) begin
    cyphertext_i       <= (int'(pc_o) < NB) ? mem_ct[int'(pc_o)] : 128'h0;
    key_i              <= (int'(pc_o) < NB) ? mem_key[int'(pc_o)] : 128'h0;
    W3_i               <= sub_word(W3_o);
    subbyte_addround_i <= inv_sub(shift_subbyte_o);
  end

  // ---------------- per-cycle checking ----------------
  task automatic step_cycle();
    int start;
    logic [31:0] x;
    @(posedge clk_i);
    cyc++;
    @(negedge clk_i);
    if (nstrobe < NB) begin
      start = (nstrobe == 0) ? 0 : exp_t[nstrobe-1];
      if (cyc == start + 3) begin
        x = mem_key[nstrobe][31:0];
        check_eq("w3_first_issue", 128'(W3_o), exp_hit[nstrobe] ? 128'h0 : 128'({x[23:0], x[31:24]}));
      end
      if (nstrobe == 0 && cyc == exp_t[0] - 21)
        check_eq("k10_fips_b", dut.key_q, K10_B);
      if (cyc == exp_t[nstrobe] - 20) begin
        x = exp_k10[nstrobe][31:0] ^ exp_k10[nstrobe][63:32];
        check_eq("w3_inv_issue", 128'(W3_o), 128'({x[23:0], x[31:24]}));
        check_eq("shift_r10", shift_subbyte_o, inv_shift(mem_ct[nstrobe] ^ exp_k10[nstrobe]));
      end
    end
    if (nstrobe < NB && cyc == exp_t[nstrobe]) begin
      check_eq("finish_hi", 128'(finish_o), 128'h1);
      check_eq("pc_at_finish", 128'(pc_o), 128'(nstrobe));
      check_eq("plaintext", m3_reg_o, exp_pt[nstrobe]);
      check_eq("w3_idle", 128'(W3_o), 128'h0);
      if (mem_key[nstrobe] == KEY_B && mem_ct[nstrobe] == CT_B) check_eq("fips_b_pt", m3_reg_o, PT_B);
      if (mem_key[nstrobe] == KEY_C && mem_ct[nstrobe] == CT_C) check_eq("fips_c1_pt", m3_reg_o, PT_C);
      nstrobe++;
    end else begin
      check_eq("finish_lo", 128'(finish_o), 128'h0);
      if (nstrobe == NB) begin
        check_eq("done_pc", 128'(pc_o), 128'(NB - 1));
        check_eq("done_m3", m3_reg_o, exp_pt[NB-1]);
        check_eq("done_w3", 128'(W3_o), 128'h0);
      end
    end
  endtask

  task automatic release_reset();
    @(negedge clk_i);
    rst_ni  = 1'b1;
    cyc     = 1;
    nstrobe = 0;
  endtask

  initial begin
    int t;
    rst_ni = 1'b0;
    cyc = 0;
    nstrobe = 0;

    // S-box from GF(2^8) inverse plus the affine transform.
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      logic [7:0] s;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox[x] = s;
      isbox[s] = x[7:0];
    end

    mem_key[0] = KEY_B; mem_ct[0] = CT_B;
    mem_key[1] = KEY_C; mem_ct[1] = CT_C;
    mem_key[2] = rand128(); mem_ct[2] = rand128();
    mem_key[3] = mem_key[2]; mem_ct[3] = rand128();
    for (int k = 4; k < NB; k++) begin
      case ($urandom_range(0, 3))
        0:       begin mem_key[k] = KEY_B; mem_ct[k] = CT_B; end
        1:       begin mem_key[k] = KEY_C; mem_ct[k] = CT_C; end
        2:       begin mem_key[k] = rand128(); mem_ct[k] = rand128(); end
        default: begin mem_key[k] = mem_key[k-1]; mem_ct[k] = rand128(); end
      endcase
    end

    t = 0;
    for (int k = 0; k < NB; k++) begin
      exp_pt[k]  = decrypt(mem_ct[k], mem_key[k]);
      exp_k10[k] = round_key(mem_key[k], 10);
      exp_hit[k] = 1'b0;
`ifdef AES_KEY_REUSE_EN
      if (k > 0 && mem_key[k] == mem_key[k-1]) exp_hit[k] = 1'b1;
`endif
      t = t + (exp_hit[k] ? 24 : 44);
      exp_t[k] = t;
    end

    // Reset values while reset is held.
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_eq("rst_m3", m3_reg_o, 128'h0);
    check_eq("rst_finish", 128'(finish_o), 128'h0);
    check_eq("rst_pc", 128'(pc_o), 128'h0);
    check_eq("rst_w3", 128'(W3_o), 128'h0);

    // Full run over all blocks, then linger in DONE.
    release_reset();
    check_eq("fetch_w3", 128'(W3_o), 128'h0);
    while (cyc < exp_t[NB-1] + 40) step_cycle();
    check_eq("strobe_count", 128'(nstrobe), 128'(NB));

    // Abort block 1 in its cycle 30 with an asynchronous reset.
    rst_ni = 1'b0;
    release_reset();
    while (cyc < exp_t[0] + 30) step_cycle();
    check_eq("pc_before_abort", 128'(pc_o), 128'h1);
    #2 rst_ni = 1'b0;
    #1;
    check_eq("abort_m3", m3_reg_o, 128'h0);
    check_eq("abort_finish", 128'(finish_o), 128'h0);
    check_eq("abort_pc", 128'(pc_o), 128'h0);
    check_eq("abort_w3", 128'(W3_o), 128'h0);
    release_reset();
    while (cyc < exp_t[0] + 5) step_cycle();
    check_eq("restart_strobes", 128'(nstrobe), 128'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
